// File: rtl/commit_trace_arbiter.sv
// Round-robin arbiter sharing one commit-trace sink between two commit requesters,
// with a small in-order FIFO and a registered output stage.
module commit_trace_arbiter #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [W-1:0]               req0_pc,
  input  logic [W-1:0]               req0_nextpc,
  input  logic [W-1:0]               req0_inst,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [W-1:0]               req1_pc,
  input  logic [W-1:0]               req1_nextpc,
  input  logic [W-1:0]               req1_inst,
  input  logic                       out_ready,
  output logic                       dpi_valid,
  output logic [W-1:0]               dpi_pc,
  output logic [W-1:0]               dpi_nextpc,
  output logic [W-1:0]               dpi_inst,
  output logic                       dpi_src,
  output logic [31:0]                dpi_seq,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = 3 * W + 1;

  // Handshake: a record moves on a rising edge where valid & ready are both high.
  // ready never depends on out_ready, so a full FIFO blocks even when the head pops.
  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          prio;
  logic          emitted_any;
  logic          space;
  logic          grant0;
  logic          grant1;
  logic          push;
  logic          pop;
  logic [RW-1:0] push_rec;

  assign space      = (count != CW'(DEPTH));
  assign grant0     = req0_valid & (~req1_valid | ~prio);
  assign grant1     = req1_valid & (~req0_valid | prio);
  assign req0_ready = reset & space & grant0;
  assign req1_ready = reset & space & grant1;
  assign push       = req0_ready | req1_ready;
  assign pop        = reset & out_ready & (count != '0);
  assign push_rec   = req1_ready ? {1'b1, req1_pc, req1_nextpc, req1_inst}
                                 : {1'b0, req0_pc, req0_nextpc, req0_inst};
  assign fifo_count = count;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      prio        <= 1'b0;
      emitted_any <= 1'b0;
      dpi_valid   <= 1'b0;
      dpi_pc      <= '0;
      dpi_nextpc  <= '0;
      dpi_inst    <= '0;
      dpi_src     <= 1'b0;
      dpi_seq     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      // Contended accept hands priority to the requester that lost.
      if (req0_valid && req1_valid && push) prio <= req0_ready;
      dpi_valid <= pop;
      if (pop) begin
        {dpi_src, dpi_pc, dpi_nextpc, dpi_inst} <= mem[rd_ptr];
        dpi_seq     <= emitted_any ? dpi_seq + 32'd1 : 32'd0;
        emitted_any <= 1'b1;
      end
    end
  end

endmodule

// File: doc/commit_trace_arbiter.md
Name: commit_trace_arbiter

Overview:
- Shares the single simulation commit-trace sink (pc/nextpc/inst/valid DPI record port) between two commit requesters.
  - Requester 0: main writeback retire.
  - Requester 1: trap/CSR redirect commit.
- Round-robin arbitration, small FIFO buffering and a registered output stage, so the sink sees at most one record per cycle, in accept order.
- Sits between the core's commit stages and the DPI trace module at top level.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
W, 32, width of pc/nextpc/inst fields

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
req0_valid  in  1  requester 0 has a commit record
req0_ready  out  1  record 0 accepted this cycle when valid&ready
req0_pc  in  W  requester 0 pc
req0_nextpc  in  W  requester 0 next pc
req0_inst  in  W  requester 0 instruction
req1_valid  in  1  requester 1 has a commit record
req1_ready  out  1  record 1 accepted this cycle
req1_pc  in  W  requester 1 pc
req1_nextpc  in  W  requester 1 next pc
req1_inst  in  W  requester 1 instruction
out_ready  in  1  sink may take a record (0 = simulation hold)
dpi_valid  out  1  registered; record on dpi_* valid this cycle
dpi_pc  out  W  registered record pc
dpi_nextpc  out  W  registered record next pc
dpi_inst  out  W  registered record instruction
dpi_src  out  1  requester id of emitted record
dpi_seq  out  32  count of records emitted before this one
fifo_count  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Single clock domain. Reset is synchronous, active-low: on a rising clock edge with reset==0, all state clears.
  - Reset values: dpi_valid=0, dpi_pc/dpi_nextpc/dpi_inst=0, dpi_src=0, dpi_seq=0, fifo_count=0.
  - Pointers clear; round-robin priority resets to requester 0.
  - Reset asserted mid-operation discards all buffered records. Ready outputs are 0 while reset==0.
- Arbitration (combinational):
  - space = (fifo_count != DEPTH).
  - Only one valid: that requester is granted if space.
  - Both valid: the requester holding priority is granted if space.
  - reqN_ready = space & grantN. At most one ready per cycle; both ready=0 when full (no push-through on simultaneous pop).
- Priority update: after a cycle where both were valid and one was accepted, priority passes to the other requester. Otherwise priority is unchanged.
- Push: on accept, {src,pc,nextpc,inst} is written at wr_ptr. wr_ptr increments mod DEPTH.
- Pop: when fifo_count!=0 & out_ready, the head entry is read, rd_ptr increments mod DEPTH, and the output registers load the entry.
  - Next cycle: dpi_valid=1, dpi_seq = previous dpi_seq+1. The first record carries dpi_seq=0.
  - dpi_seq is a pre-increment counter and wraps 0xFFFFFFFF->0.
- No pop this cycle: next cycle dpi_valid=0; dpi_pc/nextpc/inst/src/seq hold their last values.
- Push and pop in the same cycle: count unchanged. Push into empty FIFO: not poppable until the next cycle.
- Latency: record accepted at edge t is emitted with dpi_valid high in the cycle after edge t+1 (2 cycles min, FIFO empty, out_ready=1).
- Throughput: 1 record/cycle.
- Ordering: emission order equals acceptance order. No record is dropped or duplicated.
- Requester inputs are sampled only on the accepting edge. A requester must hold valid and data until ready.

Test Plan:
- Reset release, no requests, out_ready=1 for 10 cycles -> dpi_valid stays 0, fifo_count=0, dpi_seq=0.
- req0 only, pc=0x80000000,0x80000004,0x80000008 back-to-back, out_ready=1 -> req0_ready=1 each cycle; dpi_valid high 2 cycles after each accept, same pcs in order, dpi_src=0, dpi_seq=0,1,2.
- Both valid continuously (req0 pc 0x100.., req1 pc 0x200..), out_ready=1 -> grants alternate 0,1,0,1 starting with 0; dpi_src alternates; no record lost.
- out_ready=0, req0 streams 6 records, DEPTH=4 -> 4 accepted, then req0_ready=0 with fifo_count=4. Raise out_ready -> 4 records emitted in order, then remaining 2 accepted and emitted, dpi_seq 0..5.
- Reset low mid-stream with fifo_count=3 -> next cycle fifo_count=0, dpi_valid=0, dpi_seq=0, priority=req0; old records never emitted.
- Force dpi_seq to 0xFFFFFFFF via 2^32-1 emissions (or backdoor preload), emit one more -> dpi_seq wraps to 0.
